// File: rtl/lfsr.sv
// Fibonacci LFSR keystream source (Grain-80 recurrence), parallel-loadable from a seed.
// Shifts right one step per enabled clock; the feedback bit enters the MSB.
module lfsr #(
    parameter int               WIDTH = 80,
    parameter logic [WIDTH-1:0] TAPS  = 80'h0000_4008_0040_0080_2001
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             Par_load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] SEED,
    output logic [WIDTH-1:0] X,
    output logic             ser_out
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             feedback;

    // Load takes priority over shifting; with neither strobe the state holds.
    always_comb begin
        state_d  = state_q;
        feedback = ^(state_q & TAPS);
        if (Par_load) begin
            state_d = SEED;
        end else if (shift_en) begin
            state_d = {feedback, state_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign X       = state_q;
    assign ser_out = state_q[0];

endmodule

// File: tb/tb_lfsr.sv
// Directed self-checking bench for lfsr: reset, load, shift, hold, reload priority,
// asynchronous reset and the all-zero fixed point.
module tb_lfsr;

    logic        Clk;
    logic        reset;
    logic        Par_load;
    logic        shift_en;
    logic [79:0] SEED;
    logic [79:0] X;
    logic        ser_out;

    int total;
    int bad;
    logic [79:0] model;

    lfsr dut (
        .Clk      (Clk),
        .reset    (reset),
        .Par_load (Par_load),
        .shift_en (shift_en),
        .SEED     (SEED),
        .X        (X),
        .ser_out  (ser_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference recurrence s(i+80) = s(i+62)^s(i+51)^s(i+38)^s(i+23)^s(i+13)^s(i).
    function automatic logic [79:0] nextState(input logic [79:0] s);
        logic fbBit;
        fbBit = s[62] ^ s[51] ^ s[38] ^ s[23] ^ s[13] ^ s[0];
        return {fbBit, s[79:1]};
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        Par_load = 1'b0;
        shift_en = 1'b0;
        SEED     = 80'h0;
        #12;
        total++;
        if (X !== 80'h0) begin
            bad++;
            $display("[TB] FAIL reset_x actual=%h required=%h", X, 80'h0);
        end
        total++;
        if (ser_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ser actual=%b required=%b", ser_out, 1'b0);
        end
        @(negedge Clk);
        reset = 1'b1;
        tick();
        total++;
        if (X !== 80'h0) begin
            bad++;
            $display("[TB] FAIL after_release_x actual=%h required=%h", X, 80'h0);
        end
    endtask

    task automatic test_load();
        Par_load = 1'b1;
        SEED     = 80'h123456789ABCDEF12345;
        tick();
        Par_load = 1'b0;
        model    = 80'h123456789ABCDEF12345;
        total++;
        if (X !== 80'h123456789ABCDEF12345) begin
            bad++;
            $display("[TB] FAIL load_x actual=%h required=%h", X, 80'h123456789ABCDEF12345);
        end
        total++;
        if (ser_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_ser actual=%b required=%b", ser_out, 1'b1);
        end
    endtask

    task automatic test_shift();
        shift_en = 1'b1;
        tick();
        model = nextState(model);
        total++;
        if (X !== 80'h891A2B3C4D5E6F7891A2) begin
            bad++;
            $display("[TB] FAIL first_shift_x actual=%h required=%h", X, 80'h891A2B3C4D5E6F7891A2);
        end
        total++;
        if (ser_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_shift_ser actual=%b required=%b", ser_out, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            model = nextState(model);
            total++;
            if (X !== model || ser_out !== model[0]) begin
                bad++;
                $display("[TB] FAIL shift_step%0d actual=%h/%b required=%h/%b",
                         i, X, ser_out, model, model[0]);
            end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            SEED = {$urandom, $urandom, 16'hBEEF};
            tick();
            total++;
            if (X !== model) begin
                bad++;
                $display("[TB] FAIL hold%0d actual=%h required=%h", i, X, model);
            end
        end
    endtask

    task automatic test_reload();
        shift_en = 1'b1;
        tick();
        tick();
        model = nextState(nextState(model));
        total++;
        if (X !== model) begin
            bad++;
            $display("[TB] FAIL pre_reload actual=%h required=%h", X, model);
        end
        Par_load = 1'b1;
        SEED     = 80'h114313ecba9118200465;
        tick();
        Par_load = 1'b0;
        model    = 80'h114313ecba9118200465;
        total++;
        if (X !== 80'h114313ecba9118200465) begin
            bad++;
            $display("[TB] FAIL reload_x actual=%h required=%h", X, 80'h114313ecba9118200465);
        end
        total++;
        if (ser_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reload_ser actual=%b required=%b", ser_out, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            model = nextState(model);
            total++;
            if (X !== model) begin
                bad++;
                $display("[TB] FAIL resume_step%0d actual=%h required=%h", i, X, model);
            end
        end
    endtask

    task automatic test_async_reset();
        // Still shifting from the previous scenario; pull reset mid-cycle.
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (X !== 80'h0 || ser_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_clear actual=%h/%b required=%h/%b", X, ser_out, 80'h0, 1'b0);
        end
        tick();
        @(negedge Clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (X !== 80'h0) begin
                bad++;
                $display("[TB] FAIL post_reset_shift%0d actual=%h required=%h", i, X, 80'h0);
            end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_zero_seed();
        Par_load = 1'b1;
        SEED     = 80'h5;
        tick();
        SEED = 80'h0;
        tick();
        Par_load = 1'b0;
        shift_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (X !== 80'h0 || ser_out !== 1'b0) begin
                bad++;
                $display("[TB] FAIL zero_seed%0d actual=%h/%b required=%h/%b",
                         i, X, ser_out, 80'h0, 1'b0);
            end
        end
        shift_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model = 80'h0;
        test_reset();
        test_load();
        test_shift();
        test_hold();
        test_reload();
        test_async_reset();
        test_zero_seed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr.md
Name: lfsr

Overview:
- 80-bit Fibonacci linear-feedback shift register used as a pseudo-random bit/keystream source.
- The register is parallel-loadable from a seed word. It then advances one step per enabled clock, shifting right and emitting one serial bit per step.
- The full state is exposed in parallel.

Parameters:
- WIDTH, 80, register length in bits; the tap set below is defined for 80 only.
- TAPS, 80'h0000_4008_0040_0080_2001, feedback tap mask: bits 0, 13, 23, 38, 51, 62. This is the Grain-80 LFSR recurrence s(i+80) = s(i+62)^s(i+51)^s(i+38)^s(i+23)^s(i+13)^s(i).

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Par_load  input  1  parallel load strobe; when high, SEED is copied into the register.
- shift_en  input  1  shift enable; when high and Par_load is low, the LFSR advances one step.
- SEED  input  80  seed value for parallel load.
- X  output  80  current register state.
- ser_out  output  1  serial output, always equal to X[0] (combinational from state).

Behaviour:
- Port order for positional instantiation is Clk, reset, Par_load, shift_en, SEED, X, ser_out.
- Reset: reset low clears X to 80'h0 immediately, independent of Clk. ser_out reads 0 while reset is held. Reset dominates all other inputs.
- Priority on each rising edge while reset is high:
  - Par_load=1: X <= SEED. Load wins over shift_en.
  - Par_load=0 and shift_en=1: shift one step (below).
  - Both low: X holds.
- Shift step:
  - fb = XOR of X[k] for every k with TAPS[k]=1, i.e. X[62]^X[51]^X[38]^X[23]^X[13]^X[0].
  - X <= {fb, X[79:1]}: shift right, feedback enters the MSB, old X[0] leaves.
- Latency:
  - The loaded value is visible on X after the same edge that samples Par_load.
  - One shift per enabled edge; no pipelining.
- ser_out is continuously X[0], so it presents the bit that the next shift will discard. After a load it immediately shows SEED[0].
- The all-zero state is a fixed point: shifting from 0 keeps X=0. No lockup recovery; the user must load a nonzero seed.
- SEED changes have no effect unless Par_load is high at the edge.
- Reset asserted mid-sequence clears X asynchronously. After release, X stays 0 until a load.
- Inputs are synchronous to Clk. No enable-hold requirement beyond setup/hold.

Test Plan:
- Reset then load: drive reset=0, then release. X=0 and ser_out=0. Apply Par_load=1 with SEED=80'h123456789ABCDEF12345 for one edge: X=80'h123456789ABCDEF12345 and ser_out=1.
- First shift from that seed: Par_load=0, shift_en=1 for one edge. fb=1, so X=80'h891A2B3C4D5E6F7891A2 and ser_out=0. Continue ~12 shifts and compare each step against a reference model of the recurrence.
- Hold: shift_en=0 and Par_load=0 for several edges -> X unchanged. Changing SEED meanwhile has no effect.
- Reload mid-run: after shifting, assert Par_load=1 with shift_en=1 simultaneously and SEED=80'h114313ecba9118200465. X=80'h114313ecba9118200465 (load priority) and ser_out=1. Then resume shifting against the model.
- Async reset mid-run: pull reset low between clock edges while shifting. X clears to 0 immediately without a clock edge. After release with shift_en=1, X stays 0 (zero fixed point).
- Zero seed: load 80'h0, then shift 5 edges -> X remains 0 and ser_out remains 0.
